// File: rtl/sprite_scheduler.sv
// sprite_scheduler: builds each scanline's sprite list during hblank and
// arbitrates sprite ownership per pixel for the sprite ROM lookup.
module sprite_scheduler #(
    parameter int NUM_SPRITES      = 4,
    parameter int X_BITS           = 10,
    parameter int Y_BITS           = 10,
    parameter int SCALE_LOG2       = 3,
    parameter int ANIM_PERIOD_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [X_BITS-1:0]                pixel_x,
    input  logic [Y_BITS-1:0]                pixel_y,
    input  logic                             hblank_start,
    input  logic                             line_begin,
    input  logic                             frame_start,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_SPRITES)+1:0]   cfg_addr,
    input  logic [15:0]                      cfg_wdata,
    output logic                             hit_valid,
    output logic [$clog2(NUM_SPRITES)-1:0]   hit_id,
    output logic [5:0]                       local_x,
    output logic [5:0]                       local_y,
    output logic                             anim_phase,
    output logic                             scan_busy
);

    localparam int IW = $clog2(NUM_SPRITES);
    localparam int FW = ANIM_PERIOD_LOG2 + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_nx;

    logic [X_BITS-1:0] sh_left [NUM_SPRITES];
    logic [Y_BITS-1:0] sh_top  [NUM_SPRITES];
    logic [5:0]        sh_w    [NUM_SPRITES];
    logic [5:0]        sh_h    [NUM_SPRITES];
    logic              sh_en   [NUM_SPRITES];

    logic [X_BITS-1:0] lv_left [NUM_SPRITES];
    logic [Y_BITS-1:0] lv_top  [NUM_SPRITES];
    logic [5:0]        lv_w    [NUM_SPRITES];
    logic [5:0]        lv_h    [NUM_SPRITES];
    logic              lv_en   [NUM_SPRITES];

    logic [IW-1:0]          idx;
    logic [Y_BITS-1:0]      target_y;
    logic [NUM_SPRITES-1:0] pending;
    logic [NUM_SPRITES-1:0] active;
    logic [5:0]             prow [NUM_SPRITES];
    logic [5:0]             arow [NUM_SPRITES];

    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_field;
    logic          unused_wdata;

    logic [Y_BITS:0]   ty_ext;
    logic [Y_BITS:0]   top_ext;
    logic [Y_BITS:0]   bot_ext;
    logic [Y_BITS-1:0] ydiff;
    logic [5:0]        scan_row;
    logic              scan_hit;

    logic [X_BITS:0]   px_ext;
    logic [X_BITS:0]   xl;
    logic [X_BITS:0]   xr;
    logic [X_BITS-1:0] xdiff;
    logic              win_v;
    logic [IW-1:0]     win_id;
    logic [5:0]        win_lx;
    logic [5:0]        win_ly;

    logic [FW-1:0] frame_cnt;

    assign cfg_idx      = cfg_addr[IW+1:2];
    assign cfg_field    = cfg_addr[1:0];
    assign unused_wdata = ^cfg_wdata;

    // Shadow descriptor writes; whole shadow bank commits to live per frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_left[i] <= '0;
                sh_top[i]  <= '0;
                sh_w[i]    <= '0;
                sh_h[i]    <= '0;
                sh_en[i]   <= 1'b0;
                lv_left[i] <= '0;
                lv_top[i]  <= '0;
                lv_w[i]    <= '0;
                lv_h[i]    <= '0;
                lv_en[i]   <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    lv_left[i] <= sh_left[i];
                    lv_top[i]  <= sh_top[i];
                    lv_w[i]    <= sh_w[i];
                    lv_h[i]    <= sh_h[i];
                    lv_en[i]   <= sh_en[i];
                end
            end
            if (cfg_we) begin
                case (cfg_field)
                    2'd0: sh_left[cfg_idx] <= cfg_wdata[X_BITS-1:0];
                    2'd1: sh_top[cfg_idx]  <= cfg_wdata[Y_BITS-1:0];
                    2'd2: begin
                        sh_w[cfg_idx] <= cfg_wdata[5:0];
                        sh_h[cfg_idx] <= cfg_wdata[13:8];
                    end
                    default: sh_en[cfg_idx] <= cfg_wdata[0];
                endcase
            end
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Scan next-state; hblank_start restarts the scan from any state.
    always_comb begin
        state_nx = state;
        case (state)
            SCAN:    if (idx == LAST) state_nx = DONE;
            DONE:    if (line_begin) state_nx = IDLE;
            default: state_nx = state;
        endcase
        if (hblank_start) state_nx = SCAN;
    end

    // Scan outputs.
    always_comb begin
        scan_busy = (state != IDLE);
    end

    // Vertical test of the sprite under the scan pointer, no wrap.
    always_comb begin
        ty_ext   = {1'b0, target_y};
        top_ext  = {1'b0, lv_top[idx]};
        bot_ext  = top_ext + ((Y_BITS+1)'(lv_h[idx]) << SCALE_LOG2);
        ydiff    = target_y - lv_top[idx];
        scan_row = 6'(ydiff >> SCALE_LOG2);
        scan_hit = lv_en[idx] && (lv_h[idx] != 6'd0) &&
                   (lv_w[idx] != 6'd0) &&
                   (ty_ext >= top_ext) && (ty_ext < bot_ext);
    end

    // Pending list build and per-line swap into the active list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            target_y <= '0;
            pending  <= '0;
            active   <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                prow[i] <= '0;
                arow[i] <= '0;
            end
        end else begin
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (scan_hit) begin
                    pending[idx] <= 1'b1;
                    prow[idx]    <= scan_row;
                end
            end
            if (line_begin) begin
                active  <= (state == DONE) ? pending : '0;
                pending <= '0;
                for (int i = 0; i < NUM_SPRITES; i++) arow[i] <= prow[i];
            end
            if (hblank_start) begin
                target_y <= pixel_y + 1'b1;
                idx      <= '0;
                pending  <= '0;
            end
        end
    end

    // Horizontal hit per sprite; walking down makes the lowest index win.
    always_comb begin
        px_ext = {1'b0, pixel_x};
        xl     = '0;
        xr     = '0;
        xdiff  = '0;
        win_v  = 1'b0;
        win_id = '0;
        win_lx = '0;
        win_ly = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            xl = {1'b0, lv_left[i]};
            xr = xl + ((X_BITS+1)'(lv_w[i]) << SCALE_LOG2);
            if (active[i] && (px_ext >= xl) && (px_ext < xr)) begin
                xdiff  = pixel_x - lv_left[i];
                win_v  = 1'b1;
                win_id = IW'(i);
                win_lx = 6'(xdiff >> SCALE_LOG2);
                win_ly = arow[i];
            end
        end
    end

    // Registered pixel result plus animation frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_valid  <= 1'b0;
            hit_id     <= '0;
            local_x    <= '0;
            local_y    <= '0;
            anim_phase <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            hit_valid  <= win_v;
            hit_id     <= win_id;
            local_x    <= win_lx;
            local_y    <= win_ly;
            anim_phase <= frame_cnt[FW-1];
            if (frame_start) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: directed vectors for the sprite scheduler,
// expected values hand-computed from the descriptor geometry.
module tb_sprite_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       hblank_start = 1'b0;
    logic       line_begin = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic       hit_valid;
    logic [1:0] hit_id;
    logic [5:0] local_x;
    logic [5:0] local_y;
    logic       anim_phase;
    logic       scan_busy;

    int vectors = 0;
    int miscompares = 0;
    int fcnt = 0;

    sprite_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .hblank_start (hblank_start),
        .line_begin   (line_begin),
        .frame_start  (frame_start),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .hit_valid    (hit_valid),
        .hit_id       (hit_id),
        .local_x      (local_x),
        .local_y      (local_y),
        .anim_phase   (anim_phase),
        .scan_busy    (scan_busy)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(int idx, int field, int data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 4'((idx << 2) | field);
        cfg_wdata = 16'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        fcnt++;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // frame_start with a descriptor write landing in the same cycle
    task automatic frame_wr(int idx, int field, int data);
        @(negedge clk);
        frame_start = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = 4'((idx << 2) | field);
        cfg_wdata   = 16'(data);
        fcnt++;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_we      = 1'b0;
    endtask

    // Full hblank scan followed by line_begin for line y
    task automatic prep_line(int y);
        @(negedge clk);
        pixel_y      = 10'(y - 1);
        hblank_start = 1'b1;
        @(negedge clk);
        hblank_start = 1'b0;
        check("busy_scan", scan_busy, 1);
        repeat (6) @(negedge clk);
        line_begin = 1'b1;
        pixel_y    = 10'(y);
        @(negedge clk);
        line_begin = 1'b0;
        check("busy_idle", scan_busy, 0);
    endtask

    task automatic pix(string tag, int x, int v, int id, int lx, int ly);
        @(negedge clk);
        pixel_x = 10'(x);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, hit_valid, v);
        check({tag, ".id"}, hit_id, id);
        check({tag, ".lx"}, local_x, lx);
        check({tag, ".ly"}, local_y, ly);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", hit_valid, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_anim", anim_phase, 0);
        rst_n = 1'b1;

        // idle lines with nothing enabled
        prep_line(10);
        pix("idle_a", 0, 0, 0, 0, 0);
        pix("idle_b", 300, 0, 0, 0, 0);
        prep_line(11);
        pix("idle_c", 48, 0, 0, 0, 0);

        // sprite0 left=48 top=128 w=27 h=17: x 48..263, y 128..263
        wr(0, 0, 48);
        wr(0, 1, 128);
        wr(0, 2, 16'h111B);
        wr(0, 3, 1);
        prep_line(128);
        pix("pre_commit", 100, 0, 0, 0, 0);
        frame();
        prep_line(128);
        pix("s0_x47", 47, 0, 0, 0, 0);
        pix("s0_x48", 48, 1, 0, 0, 0);
        pix("s0_x55", 55, 1, 0, 0, 0);
        pix("s0_x56", 56, 1, 0, 1, 0);
        pix("s0_x263", 263, 1, 0, 26, 0);
        pix("s0_x264", 264, 0, 0, 0, 0);
        prep_line(127);
        pix("s0_y127", 100, 0, 0, 0, 0);
        prep_line(263);
        pix("s0_y263", 100, 1, 0, 6, 16);
        prep_line(264);
        pix("s0_y264", 100, 0, 0, 0, 0);

        // overlap: s0 x 100..131, s1 x 90..121, line 140 -> row 1
        wr(0, 0, 100);
        wr(0, 2, 16'h1104);
        wr(1, 0, 90);
        wr(1, 1, 128);
        wr(1, 2, 16'h1104);
        wr(1, 3, 1);
        frame();
        prep_line(140);
        pix("ov_x89", 89, 0, 0, 0, 0);
        pix("ov_x90", 90, 1, 1, 0, 1);
        pix("ov_x99", 99, 1, 1, 1, 1);
        pix("ov_x100", 100, 1, 0, 0, 1);
        pix("ov_x121", 121, 1, 0, 2, 1);
        pix("ov_x122", 122, 1, 0, 2, 1);
        pix("ov_x131", 131, 1, 0, 3, 1);
        pix("ov_x132", 132, 0, 0, 0, 0);

        // write coincident with frame_start waits one more frame
        wr(1, 3, 0);
        frame();
        frame_wr(0, 0, 200);
        prep_line(130);
        pix("same_old", 100, 1, 0, 0, 0);
        pix("same_new", 200, 0, 0, 0, 0);
        frame();
        prep_line(130);
        pix("next_old", 100, 0, 0, 0, 0);
        pix("next_new", 200, 1, 0, 0, 0);
        pix("next_end", 231, 1, 0, 3, 0);
        pix("next_out", 232, 0, 0, 0, 0);

        // hblank re-pulsed mid-scan restarts with new target line
        @(negedge clk);
        pixel_y      = 10'd9;
        hblank_start = 1'b1;
        @(negedge clk);
        hblank_start = 1'b0;
        check("rs_busy0", scan_busy, 1);
        @(negedge clk);
        check("rs_busy1", scan_busy, 1);
        pixel_y      = 10'd129;
        hblank_start = 1'b1;
        @(negedge clk);
        hblank_start = 1'b0;
        check("rs_busy2", scan_busy, 1);
        repeat (6) @(negedge clk);
        line_begin = 1'b1;
        pixel_y    = 10'd130;
        @(negedge clk);
        line_begin = 1'b0;
        pix("rs_hit", 200, 1, 0, 0, 0);

        // line_begin before scan completes -> empty line
        @(negedge clk);
        pixel_y      = 10'd129;
        hblank_start = 1'b1;
        @(negedge clk);
        hblank_start = 1'b0;
        @(negedge clk);
        line_begin = 1'b1;
        @(negedge clk);
        line_begin = 1'b0;
        pix("early_lb", 200, 0, 0, 0, 0);

        // animation phase flips after 16 frames, back after 32
        while (fcnt < 15) frame();
        repeat (2) @(negedge clk);
        check("anim_15", anim_phase, 0);
        frame();
        repeat (2) @(negedge clk);
        check("anim_16", anim_phase, 1);
        while (fcnt < 31) frame();
        repeat (2) @(negedge clk);
        check("anim_31", anim_phase, 1);
        frame();
        repeat (2) @(negedge clk);
        check("anim_32", anim_phase, 0);

        // reset mid-line
        prep_line(130);
        pix("pre_rst", 200, 1, 0, 0, 0);
        @(negedge clk);
        pixel_x = 10'd200;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", hit_valid, 0);
        check("mid_rst_busy", scan_busy, 0);
        check("mid_rst_anim", anim_phase, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prep_line(130);
        pix("post_rst", 200, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
